// File: rtl/dm_master_pkg.sv
// Shared encodings for the data-memory master: access sizes, FSM states and
// the alignment rule used to reject illegal accesses before touching memory.
package dm_master_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RD   = 2'b01,
      WR   = 2'b10,
      FIN  = 2'b11
   } dm_state_t;

   // size 11 is never legal; halves need an even address, words a 4-byte one
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = off[0];
         SZ_WORD: bad = (off != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dm_lane.sv
// Combinational little-endian lane logic: merges store data into an old word
// and extracts/extends the addressed lane of a loaded word.
module dm_lane
   import dm_master_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   input  logic [31:0] rd_word,
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic        sign,
   output logic [31:0] new_word,
   output logic [31:0] ld_data
);

   function automatic logic [31:0] extend8(input logic [7:0] v, input logic s);
      logic signed [7:0]  sv;
      logic signed [31:0] wide;
      sv   = signed'(v);
      wide = sv;
      return s ? 32'(wide) : {24'b0, v};
   endfunction

   function automatic logic [31:0] extend16(input logic [15:0] v, input logic s);
      logic signed [15:0] sv;
      logic signed [31:0] wide;
      sv   = signed'(v);
      wide = sv;
      return s ? 32'(wide) : {16'b0, v};
   endfunction

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      new_word = old_word;
      case (size)
         SZ_BYTE: new_word[{off, 3'b000} +: 8]     = wdata[7:0];
         SZ_HALF: new_word[{off[1], 4'b0000} +: 16] = wdata[15:0];
         default: new_word = wdata;
      endcase
   end

   always_comb begin
      byte_sel = rd_word[{off, 3'b000} +: 8];
      half_sel = rd_word[{off[1], 4'b0000} +: 16];
      case (size)
         SZ_BYTE: ld_data = extend8(byte_sel, sign);
         SZ_HALF: ld_data = extend16(half_sel, sign);
         default: ld_data = rd_word;
      endcase
   end

endmodule

// File: rtl/dm_master.sv
// Byte/half/word load-store master in front of a 32-bit word memory; sub-word
// stores are done as read-modify-write, misaligned accesses are rejected.
module dm_master
   import dm_master_pkg::*;
#(
   parameter int ADDR_BITS = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        sign,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        misalign,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   input  logic [31:0] mem_dout
);

   dm_state_t   state_q, state_d;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] word_q;
   logic [31:0] rdata_q;
   logic        we_q, sign_q, mis_q;
   logic [1:0]  size_q;
   logic        accept;
   logic [31:0] new_word, ld_data;

   assign accept = (state_q == IDLE) && req;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               if (is_misaligned(size, addr[1:0]))
                  state_d = FIN;
               else if (we && (size == SZ_WORD))
                  state_d = WR;
               else
                  state_d = RD;
            end
         end
         RD:      state_d = we_q ? WR : FIN;
         WR:      state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q  <= '0;
         we_q    <= 1'b0;
         size_q  <= SZ_BYTE;
         sign_q  <= 1'b0;
         mis_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         if (accept) begin
            addr_q <= addr;
            we_q   <= we;
            size_q <= size;
            sign_q <= sign;
            mis_q  <= is_misaligned(size, addr[1:0]);
         end
         // rdata only moves on the edge into FIN of a load, so it holds across stores
         if ((state_q == RD) && !we_q)
            rdata_q <= ld_data;
      end
   end

   always_ff @(posedge clk) begin
      if (accept)
         wdata_q <= wdata;
      if (state_q == RD)
         word_q <= mem_dout;
   end

   dm_lane u_lane (
      .old_word (word_q),
      .wdata    (wdata_q),
      .rd_word  (mem_dout),
      .off      (addr_q[1:0]),
      .size     (size_q),
      .sign     (sign_q),
      .new_word (new_word),
      .ld_data  (ld_data)
   );

   assign busy     = (state_q != IDLE);
   assign done     = (state_q == FIN);
   assign misalign = done && mis_q;
   assign mem_we   = (state_q == WR);
   assign mem_addr = {addr_q[31:ADDR_BITS], addr_q[ADDR_BITS-1:2], 2'b00};
   assign mem_din  = mem_we ? new_word : '0;
   assign rdata    = rdata_q;

endmodule

// File: doc/dm_master.md
DM_MASTER -- requirements
Module: dm_master

Interface
REQ-001 Parameter ADDR_BITS, default 12, is the byte-address width decoded by the attached word memory; mem_addr bits above ADDR_BITS-1 SHALL pass through unchanged.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 req  in  1  CPU access request; sampled only in IDLE.
REQ-005 we  in  1  1 = store, 0 = load.
REQ-006 size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 sign  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-008 addr  in  32  byte address.
REQ-009 wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 rdata  out  32  extended load result; valid while done=1, held until the next done.
REQ-013 misalign  out  1  high with done when the access was rejected.
REQ-014 mem_we  out  1  word-memory write enable.
REQ-015 mem_addr  out  32  word-aligned address {addr_q[31:2],2'b00}.
REQ-016 mem_din  out  32  full word to write.
REQ-017 mem_dout  in  32  combinational read word from memory at mem_addr.

Function
REQ-018 FSM states SHALL be IDLE, RD, WR, FIN; mem_we SHALL be high only in WR.
REQ-019 IDLE with req=1 SHALL register addr, wdata, we, size and sign; with req=0 the FSM SHALL stay in IDLE.
REQ-020 A misaligned access SHALL go IDLE->FIN with misalign=1 and no memory access; misaligned means size=11, size=01 with addr[0]=1, or size=10 with addr[1:0]!=0.
REQ-021 Load: IDLE->RD->FIN; RD SHALL capture mem_dout.
REQ-022 Word store: IDLE->WR->FIN; mem_din SHALL equal wdata_q.
REQ-023 Byte/half store: IDLE->RD->WR->FIN (read-modify-write).
  - RD captures the old word.
  - WR drives the old word with only the addressed lane(s) replaced by wdata_q[7:0] / wdata_q[15:0].
REQ-024 Lane select SHALL be little-endian: byte k = bits [8k+7:8k], k = addr_q[1:0]; half at addr_q[1].
REQ-025 Load result: the selected lane SHALL be sign- or zero-extended per sign_q; word loads ignore sign_q.
REQ-026 FIN SHALL assert done for exactly one cycle, then return to IDLE.
REQ-027 req asserted in FIN SHALL be ignored; a new access is accepted one cycle after FIN, at the earliest.
REQ-028 Latency from accept edge to done high SHALL be:
  - misaligned: 1 cycle
  - word store: 2 cycles
  - load: 2 cycles
  - sub-word store: 3 cycles
REQ-029 mem_addr and mem_din SHALL be stable for the whole of each RD and WR cycle.

Reset
REQ-030 reset=0 SHALL immediately force IDLE and clear the outputs, independent of clk:
  - busy=0, done=0, misalign=0, mem_we=0
  - rdata=0, mem_addr=0, mem_din=0
REQ-031 Reset asserted during WR SHALL drop mem_we in the same cycle; no partial write is required to complete.
REQ-032 After reset deasserts, the first rising edge with req=1 SHALL be accepted.

Structure
REQ-033 A shared package SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state encoding.
REQ-034 Sub-module dm_lane SHALL be combinational:
  - store path: lane merge (old word, data, offset, size -> new word)
  - load path: lane extract/extend (word, offset, size, sign -> rdata)
REQ-035 The FSM and all capture registers SHALL reside in dm_master.

Verification
REQ-036 Memory word 0x00000010 = 0x11223344; load byte, addr 0x13, sign=1 -> done 2 cycles after accept, rdata=0x00000011; same access with addr 0x10 -> rdata=0x00000044.
REQ-037 Same word; store byte 0xAB at addr 0x11 -> RD then WR cycle, mem_din=0x1122AB44, mem_we high exactly 1 cycle, done 3 cycles after accept.
REQ-038 Word 0x00000020 = 0x8000FFFF; load half at 0x20, sign=1 -> rdata=0xFFFFFFFF; load half at 0x22, sign=0 -> rdata=0x00008000.
REQ-039 Load word at addr 0x06 -> done and misalign both high 1 cycle after accept, mem_we never asserts, memory unchanged.
REQ-040 Word store of 0xDEADBEEF to 0x40 with reset pulled low during WR -> mem_we low immediately, busy=0, then a fresh load of 0x40 completes normally.
REQ-041 Back-to-back requests with req held high -> second access accepted the cycle after FIN, done pulses never adjacent.
